seg7s2p_rx: RTL and testbench

- Serial-to-parallel receiver: the receive end of the shift-register serial link driven by the 7-seg/LED P2S transmitters.
- Samples the link pins (s_clk, sin, EN) in the system clock domain and reassembles one DATA_BITS-wide word per frame.
- Flags malformed frames.
- Used for board-to-board loopback, for readback of display data, and as the checker endpoint in serial-link benches.

---
 rtl/seg7s2p_rx.sv | 114 +++++++++++
 tb/tb_seg7s2p_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7s2p_rx.sv
// rtl/seg7s2p_rx.sv - serial-to-parallel receiver for the 7-seg/LED P2S shift link
// Samples s_clk/sin/EN in the clk domain and assembles one DATA_BITS word per EN-low frame.

module seg7s2p_rx #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 5,
  parameter bit DIR             = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 sin,
  input  logic                 EN,
  output logic [DATA_BITS-1:0] PData,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [DATA_COUNT_BITS-1:0] CNT_FULL = DATA_COUNT_BITS'(DATA_BITS);
  localparam logic [DATA_COUNT_BITS-1:0] CNT_SAT  = DATA_COUNT_BITS'(DATA_BITS + 1);
  localparam logic [DATA_COUNT_BITS-1:0] CNT_ONE  = DATA_COUNT_BITS'(1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic                       sclk_q, sclk_qq, sin_q, en_q, en_qq;
  logic                       sclk_rise, en_fall, en_rise;
  logic [DATA_COUNT_BITS-1:0] count, count_nxt;
  logic [DATA_BITS-1:0]       shift_reg, shift_nxt;
  logic                       word_done, word_bad;

  // Pins share the clk source domain, so one register stage plus a delayed copy suffices.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      sin_q   <= 1'b0;
      en_q    <= 1'b0;
      en_qq   <= 1'b0;
    end else begin
      sclk_q  <= s_clk;
      sclk_qq <= sclk_q;
      sin_q   <= sin;
      en_q    <= EN;
      en_qq   <= en_q;
    end
  end

  assign sclk_rise = sclk_q & ~sclk_qq;
  assign en_fall   = ~en_q & en_qq;
  assign en_rise   = en_q & ~en_qq;

  // Shift/count as they would look after this cycle's s_clk edge, so a bit that
  // arrives together with EN rising is still counted into the frame.
  always_comb begin
    shift_nxt = shift_reg;
    count_nxt = count;
    if (sclk_rise) begin
      if (DIR) shift_nxt = {sin_q, shift_reg[DATA_BITS-1:1]};
      else     shift_nxt = {shift_reg[DATA_BITS-2:0], sin_q};
      if (count != CNT_SAT) count_nxt = count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_fall) state_nxt = RECV;
      RECV:    if (en_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RECV);
    word_done = (state == RECV) && en_rise && (count_nxt == CNT_FULL);
    word_bad  = (state == RECV) && en_rise && (count_nxt != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      shift_reg  <= '0;
      PData      <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= word_done;
      frame_err  <= word_bad;
      case (state)
        IDLE: begin
          if (en_fall) begin
            count     <= '0;
            shift_reg <= '0;
          end
        end
        RECV: begin
          count     <= count_nxt;
          shift_reg <= shift_nxt;
          if (word_done) PData <= shift_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7s2p_rx.sv
// tb/tb_seg7s2p_rx.sv - self-checking bench for seg7s2p_rx, DIR=0 and DIR=1 side by side
// Table vectors, hand-built corner sequences, and randomized frames against a bit-order model.

module tb_seg7s2p_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_clk = 1'b0;
  logic        sin = 1'b0;
  logic        EN = 1'b1;
  logic [15:0] pdata0, pdata1;
  logic        dv0, fe0, busy0, dv1, fe1, busy1;

  seg7s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .DIR(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .sin(sin), .EN(EN),
    .PData(pdata0), .data_valid(dv0), .frame_err(fe0), .busy(busy0)
  );

  seg7s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .DIR(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .sin(sin), .EN(EN),
    .PData(pdata1), .data_valid(dv1), .frame_err(fe1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nbits;
    logic [31:0] bits;
    bit          tail;
    int          half;
    bit          exp_dv;
    bit          exp_fe;
    logic [15:0] exp_p0;
    logic [15:0] exp_p1;
  } vec_t;

  vec_t        tbl[4];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          dv0_cnt = 0, fe0_cnt = 0, dv1_cnt = 0, fe1_cnt = 0, both_cnt = 0;
  int          last_pulse_cyc = 0;
  int          en_cyc = 0;
  logic [15:0] pq[$];
  logic [15:0] m_p0 = '0, m_p1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv0) begin
      dv0_cnt        <= dv0_cnt + 1;
      last_pulse_cyc <= cyc;
      pq.push_back(pdata0);
    end
    if (fe0) begin
      fe0_cnt        <= fe0_cnt + 1;
      last_pulse_cyc <= cyc;
    end
    if (dv1) dv1_cnt <= dv1_cnt + 1;
    if (fe1) fe1_cnt <= fe1_cnt + 1;
    if ((dv0 && fe0) || (dv1 && fe1)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sends n bits, first one taken from bits[n-1]; tail raises EN on the final s_clk edge.
  task automatic send_bits(input int n, input logic [31:0] bits, input int half, input bit tail);
    for (int i = 0; i < n; i++) begin
      sin = bits[n-1-i];
      repeat (half) @(negedge clk);
      s_clk = 1'b1;
      if (tail && i == n - 1) begin
        EN     = 1'b1;
        en_cyc = cyc;
      end
      repeat (half) @(negedge clk);
      s_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] bits, input int half,
                            input bit tail, input int gap);
    EN = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(n - 1, bits >> 1, half, 1'b0);
    check("busy_in_frame", {30'd0, busy0, busy1}, 32'd3);
    send_bits(1, {31'd0, bits[0]}, half, tail);
    if (!tail) begin
      EN     = 1'b1;
      en_cyc = cyc;
    end
    repeat (gap) @(negedge clk);
  endtask

  // Reference: the i-th received bit lands at bit 15-i (MSB first) or bit i (LSB first).
  task automatic model_frame(input int n, input logic [31:0] bits, output bit ok);
    ok = (n == 16);
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        m_p0[15-i] = bits[15-i];
        m_p1[i]    = bits[15-i];
      end
    end
  endtask

  task automatic run_and_check(input string name, input int n, input logic [31:0] bits,
                               input int half, input bit tail, input bit exp_dv,
                               input bit exp_fe, input logic [15:0] e0, input logic [15:0] e1);
    int d0, f0, d1, f1;
    d0 = dv0_cnt; f0 = fe0_cnt; d1 = dv1_cnt; f1 = fe1_cnt;
    send_frame(n, bits, half, tail, 5);
    check({name, "_dv0"}, dv0_cnt - d0, {31'd0, exp_dv});
    check({name, "_fe0"}, fe0_cnt - f0, {31'd0, exp_fe});
    check({name, "_dv1"}, dv1_cnt - d1, {31'd0, exp_dv});
    check({name, "_fe1"}, fe1_cnt - f1, {31'd0, exp_fe});
    check({name, "_pdata0"}, {16'd0, pdata0}, {16'd0, e0});
    check({name, "_pdata1"}, {16'd0, pdata1}, {16'd0, e1});
    check({name, "_busy_after"}, {30'd0, busy0, busy1}, 32'd0);
    check({name, "_latency"}, last_pulse_cyc - en_cyc, 32'd2);
  endtask

  initial begin
    int  d0, f0, d1, f1, qs, n, r;
    bit  ok;
    logic [31:0] data;

    tbl[0] = '{"t1_a5c3",  16, 32'h0000_A5C3, 1'b0, 2, 1'b1, 1'b0, 16'hA5C3, 16'hC3A5};
    tbl[1] = '{"t3_15bit", 15, 32'h0000_7ABC, 1'b0, 2, 1'b0, 1'b1, 16'hA5C3, 16'hC3A5};
    tbl[2] = '{"t3_17bit", 17, 32'h0001_2345, 1'b0, 2, 1'b0, 1'b1, 16'hA5C3, 16'hC3A5};
    tbl[3] = '{"t4_tail",  16, 32'h0000_FFFF, 1'b1, 2, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pdata", {pdata0, pdata1}, 32'd0);
    check("reset_pulses", {28'd0, dv0, fe0, dv1, fe1}, 32'd0);
    check("reset_busy", {30'd0, busy0, busy1}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_and_check(tbl[i].name, tbl[i].nbits, tbl[i].bits, tbl[i].half, tbl[i].tail,
                    tbl[i].exp_dv, tbl[i].exp_fe, tbl[i].exp_p0, tbl[i].exp_p1);
      model_frame(tbl[i].nbits, tbl[i].bits, ok);
    end

    // Reset in the middle of a frame, released with EN still low.
    d0 = dv0_cnt; f0 = fe0_cnt; d1 = dv1_cnt; f1 = fe1_cnt;
    EN = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8, 32'hA7, 2, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_bits(8, 32'h5C, 2, 1'b0);
    EN = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_abort_pulses", (dv0_cnt - d0) + (fe0_cnt - f0) + (dv1_cnt - d1) + (fe1_cnt - f1), 32'd0);
    check("t5_abort_pdata", {pdata0, pdata1}, 32'd0);
    m_p0 = '0; m_p1 = '0;
    run_and_check("t5_1234", 16, 32'h1234, 2, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h2C48);
    model_frame(16, 32'h1234, ok);

    // Idle s_clk activity, then two frames separated by a single EN-high clock.
    d0 = dv0_cnt; f0 = fe0_cnt;
    EN = 1'b1;
    send_bits(16, 32'hBEEF, 1, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_idle_pulses", (dv0_cnt - d0) + (fe0_cnt - f0), 32'd0);
    check("t6_idle_pdata", {pdata0, pdata1}, {16'h1234, 16'h2C48});
    check("t6_idle_busy", {30'd0, busy0, busy1}, 32'd0);
    d0 = dv0_cnt; f0 = fe0_cnt; d1 = dv1_cnt; f1 = fe1_cnt;
    qs = pq.size();
    send_frame(16, 32'h0001, 2, 1'b0, 1);
    send_frame(16, 32'h8000, 2, 1'b0, 5);
    check("t6_b2b_dv0", dv0_cnt - d0, 32'd2);
    check("t6_b2b_dv1", dv1_cnt - d1, 32'd2);
    check("t6_b2b_fe", (fe0_cnt - f0) + (fe1_cnt - f1), 32'd0);
    check("t6_b2b_qsize", pq.size() - qs, 32'd2);
    if (pq.size() >= qs + 2) begin
      check("t6_b2b_first", {16'd0, pq[qs]}, 32'h0001);
      check("t6_b2b_second", {16'd0, pq[qs+1]}, 32'h8000);
    end
    check("t6_b2b_pdata1", {16'd0, pdata1}, 32'h0001);
    model_frame(16, 32'h0001, ok);
    model_frame(16, 32'h8000, ok);

    for (int k = 0; k < 24; k++) begin
      r    = $urandom_range(0, 5);
      n    = (r == 0) ? 15 : (r == 5) ? 17 : 16;
      data = $urandom;
      data = data & ((32'd1 << n) - 32'd1);
      model_frame(n, data, ok);
      run_and_check($sformatf("rnd%0d", k), n, data, $urandom_range(1, 3),
                    1'($urandom_range(0, 1)), ok, !ok, m_p0, m_p1);
    end

    check("no_dual_pulse", both_cnt, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
